// File: rtl/seq_gen.sv
// Serial pattern generator: latches a WIDTH-bit pattern on start and shifts it out MSB-first,
// reps times with gap idle cycles between repetitions; all outputs registered, one cycle behind the FSM.
module seq_gen #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8,
  parameter int GAP_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] pat,
  input  logic [CNT_W-1:0] reps,
  input  logic [GAP_W-1:0] gap,
  output logic             ou,
  output logic             ou_vld,
  output logic             last,
  output logic             busy,
  output logic             done
);

  localparam int IW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP, S_FIN} state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] pat_q, pat_n;
  logic [WIDTH-1:0] shift, shift_n;
  logic [IW-1:0]    bit_idx, bit_idx_n;
  logic [CNT_W-1:0] rep_left, rep_left_n;
  logic [GAP_W-1:0] gap_val, gap_val_n;
  logic [GAP_W-1:0] gap_cnt, gap_cnt_n;
  logic             ou_n, ou_vld_n, last_n, busy_n, done_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      pat_q    <= '0;
      shift    <= '0;
      bit_idx  <= '0;
      rep_left <= '0;
      gap_val  <= '0;
      gap_cnt  <= '0;
      ou       <= 1'b0;
      ou_vld   <= 1'b0;
      last     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_n;
      pat_q    <= pat_n;
      shift    <= shift_n;
      bit_idx  <= bit_idx_n;
      rep_left <= rep_left_n;
      gap_val  <= gap_val_n;
      gap_cnt  <= gap_cnt_n;
      ou       <= ou_n;
      ou_vld   <= ou_vld_n;
      last     <= last_n;
      busy     <= busy_n;
      done     <= done_n;
    end
  end

  always_comb begin
    state_n    = state;
    pat_n      = pat_q;
    shift_n    = shift;
    bit_idx_n  = bit_idx;
    rep_left_n = rep_left;
    gap_val_n  = gap_val;
    gap_cnt_n  = gap_cnt;
    ou_n       = 1'b0;
    ou_vld_n   = 1'b0;
    last_n     = 1'b0;
    busy_n     = 1'b0;
    done_n     = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          pat_n      = pat;
          rep_left_n = reps;
          gap_val_n  = gap;
          if (reps != '0) begin
            shift_n   = pat;
            bit_idx_n = IW'(WIDTH - 1);
            state_n   = S_SEND;
          end else begin
            state_n   = S_FIN;
          end
        end
      end
      S_SEND: begin
        ou_n      = shift[WIDTH-1];
        ou_vld_n  = 1'b1;
        busy_n    = 1'b1;
        last_n    = (bit_idx == '0);
        shift_n   = shift << 1;
        bit_idx_n = bit_idx - 1'b1;
        if (bit_idx == '0) begin
          rep_left_n = (rep_left != '0) ? rep_left - 1'b1 : '0;
          if (rep_left <= CNT_W'(1)) begin
            state_n = S_FIN;
          end else if (gap_val != '0) begin
            gap_cnt_n = gap_val;
            state_n   = S_GAP;
          end else begin
            // back-to-back repetition: reload without a bubble
            shift_n   = pat_q;
            bit_idx_n = IW'(WIDTH - 1);
          end
        end
      end
      S_GAP: begin
        busy_n    = 1'b1;
        gap_cnt_n = gap_cnt - 1'b1;
        if (gap_cnt <= GAP_W'(1)) begin
          shift_n   = pat_q;
          bit_idx_n = IW'(WIDTH - 1);
          state_n   = S_SEND;
        end
      end
      S_FIN: begin
        done_n  = 1'b1;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

endmodule

// File: doc/seq_gen.md
# seq_gen

Serial pattern generator: on a start request it latches a WIDTH-bit pattern and shifts it out MSB-first, one bit per clock, for a programmable number of repetitions, with an optional run of idle cycles between repetitions. It is the stimulus/transmit end for the team's serial sequence detectors, such as the Mealy 1010 detectors. It sits between a control register interface (start/pattern/count) and a single-bit serial line. All outputs are registered.

## Interface
- WIDTH, 4, pattern length in bits (2..16)
- CNT_W, 8, width of the repetition count
- GAP_W, 4, width of the inter-repetition gap count
- clk  input  1  rising-edge clock
- rst  input  1  reset, synchronous, active-high
- start  input  1  request; sampled only in IDLE
- pat  input  WIDTH  pattern, latched when start is accepted
- reps  input  CNT_W  number of repetitions, latched on start; 0 = send nothing
- gap  input  GAP_W  idle cycles between repetitions, latched on start
- ou  output  1  serial data bit; 0 whenever ou_vld=0
- ou_vld  output  1  ou carries a pattern bit this cycle
- last  output  1  high with the final bit (LSB) of every repetition
- busy  output  1  high from the cycle after start is accepted until done
- done  output  1  one-cycle pulse after the final bit, or after start when reps=0

## Operation
- Reset (rst=1 at a posedge) forces the following state at the next edge: IDLE, ou=0, ou_vld=0, last=0, busy=0, done=0, and all counters cleared. This applies from any state, including mid-pattern. No partial pattern resumes after reset.
- States:
  - IDLE: waits for start.
  - SEND: shifts out the pattern.
  - GAP: idle cycles between repetitions.
  - FIN: emits done.
- IDLE -> SEND when start=1 and reps!=0. The block latches pat into a shift register, latches reps into rep_left and gap into gap_val, and sets bit_idx=WIDTH-1.
- IDLE -> FIN when start=1 and reps=0.
- SEND behaviour:
  - Each cycle: ou=shift[WIDTH-1], ou_vld=1, shift left by one, decrement bit_idx.
  - last=1 when bit_idx=0.
- On the last bit of a repetition, rep_left is decremented. The next state is:
  - FIN if rep_left becomes 0.
  - GAP if gap_val!=0.
  - Otherwise SEND again (back-to-back), with the shift register reloaded from the latched pattern and no bubble.
- GAP: ou=0, ou_vld=0 for exactly gap_val cycles, then SEND with the pattern reloaded.
- FIN: done=1 for exactly one cycle, busy=0, then IDLE. A new start can be accepted in the first IDLE cycle after FIN.
- start while busy, or in FIN, is ignored. Changes to pat, reps or gap after acceptance have no effect on the transfer in progress.
- Total bits per transfer = WIDTH*reps. Maximum reps is 2^CNT_W-1. There is no wrap-around: rep_left saturates at 0 and never underflows.

## Timing
- Latency: start accepted at edge N. The first bit (pattern MSB), with ou_vld=1 and busy=1, is visible after edge N+1.
- Bit k of a repetition (0 = MSB) appears after edge N+1+k for the first repetition.
- Repetition r (0-based) starts at offset r*(WIDTH+gap) from the first bit.
- done appears the cycle after the final bit, i.e. after edge N+1+reps*WIDTH+(reps-1)*gap. busy falls in the same cycle that done rises.
- reps=0: done is visible after edge N+1, busy stays 0, and ou_vld is never asserted.
- ou, ou_vld and last change only at clock edges. There are no combinational input-to-output paths.
- Throughput: one bit per clock while in SEND.

## Test plan
- Reset, then a single pattern:
  - Stimulus: start=1 at cycle 0, pat=4'b1010, reps=1, gap=0.
  - Response: ou=1,0,1,0 with ou_vld=1 in cycles 1-4; last=1 only in cycle 4; done=1 in cycle 5; busy=1 in cycles 1-4.
- Back-to-back repetitions:
  - Stimulus: pat=1010, reps=3, gap=0.
  - Response: 12 contiguous valid bits 101010101010 in cycles 1-12; last in cycles 4, 8 and 12; done in cycle 13. A downstream non-overlapping 1010 detector fires 3 times.
- Gapped repetitions:
  - Stimulus: pat=1101, reps=2, gap=2.
  - Response: bits 1101 in cycles 1-4; ou_vld=0 and ou=0 in cycles 5-6; bits 1101 in cycles 7-10; done in cycle 11.
- Zero repetitions and ignored start:
  - Stimulus: reps=0.
  - Response: done in cycle 1, no ou_vld.
  - Stimulus: during an active transfer, start pulses with a different pat.
  - Response: the output stream is unchanged.
- Reset mid-operation:
  - Stimulus: reps=5, with rst=1 asserted for one cycle during the third bit of repetition 2.
  - Response: all outputs are 0 on the next cycle, done is never pulsed, and a subsequent start behaves exactly as from power-up.
